// File: rtl/mmio_tohost_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mmio_tohost_if
//  Description : Data-memory port and byte-sink handshake for mmio_tohost.
//  Revision    : 1.0  initial release
// ============================================================================
interface mmio_tohost_if;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        hit;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   // master = core plus byte sink; slave = the responder
   modport master (
      output MemWrite, DataAdr, WriteData, tx_ready,
      input  ReadData, hit, tx_valid, tx_data
   );

   modport slave (
      input  MemWrite, DataAdr, WriteData, tx_ready,
      output ReadData, hit, tx_valid, tx_data
   );
endinterface
`default_nettype wire

// File: rtl/mmio_tohost.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mmio_tohost
//  Description : MMIO console FIFO, STATUS and tohost end-of-test register.
//                Define MMIO_TOHOST_CYCLE_EN to add a cycle counter at +0xC.
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_tohost #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
   parameter int          DEPTH     = 8
) (
   input  wire logic      clk,
   input  wire logic      reset,
   mmio_tohost_if.slave   bus,
   output logic           done,
   output logic           pass,
   output logic           overflow
);
   localparam int           AW       = $clog2(DEPTH);
   localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]  CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          done_q, done_d, pass_q, pass_d;
   logic [31:0]   code_q, code_d;

   logic       wr_en, push_req, push, pop, full, empty;
   logic [1:0] sel;
   logic       w_unused;

   assign bus.hit      = (bus.DataAdr[31:4] == BASE_ADDR[31:4]);
   assign sel          = bus.DataAdr[3:2];
   assign wr_en        = bus.MemWrite & bus.hit;
   assign full         = (count_q == FULL_CNT);
   assign empty        = (count_q == '0);
   assign push_req     = wr_en & (sel == 2'd0);
   assign push         = push_req & ~full;
   assign pop          = bus.tx_valid & bus.tx_ready;
   assign bus.tx_valid = ~empty;
   assign bus.tx_data  = mem_q[rptr_q];
   assign w_unused     = ^bus.DataAdr[1:0];

   assign done     = done_q;
   assign pass     = pass_q;
   assign overflow = overflow_q;

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      done_d     = done_q;
      pass_d     = pass_q;
      code_d     = code_q;
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (pop)  rptr_d = rptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (!push && pop) count_d = count_q - CNT_ONE;
      // a drop in the same cycle wins over a clear
      if (push_req && full)
         overflow_d = 1'b1;
      else if (wr_en && sel == 2'd1 && bus.WriteData[10])
         overflow_d = 1'b0;
      if (wr_en && sel == 2'd2 && !done_q) begin
         code_d = bus.WriteData;
         done_d = 1'b1;
         pass_d = (bus.WriteData == 32'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         code_q     <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         code_q     <= code_d;
      end
   end

   // storage needs no reset; validity is tracked by the count
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= bus.WriteData[7:0];
   end

   logic [31:0] cycle_rd;
`ifdef MMIO_TOHOST_CYCLE_EN
   logic [31:0] cycle_q, cycle_d;

   always_comb begin
      cycle_d = cycle_q;
      if (!done_q) cycle_d = cycle_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset) cycle_q <= '0;
      else        cycle_q <= cycle_d;
   end

   assign cycle_rd = cycle_q;
`else
   assign cycle_rd = 32'd0;
`endif

   always_comb begin
      bus.ReadData = 32'd0;
      case (sel)
         2'd1:    bus.ReadData = {21'b0, overflow_q, full, empty, 8'(count_q)};
         2'd2:    bus.ReadData = code_q;
         2'd3:    bus.ReadData = cycle_rd;
         default: bus.ReadData = 32'd0;
      endcase
   end
endmodule
`default_nettype wire
